// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the hub clock period monitors.
// Holds the monitor FSM encoding and the nominal period of every hub output.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALL
  } mon_state_e;

  // Nominal hub output periods in 50 MHz fundamental-clock cycles.
  localparam int unsigned P_5MHZ   = 10;
  localparam int unsigned P_1MHZ   = 50;
  localparam int unsigned P_100KHZ = 500;
  localparam int unsigned P_10KHZ  = 5_000;
  localparam int unsigned P_1KHZ   = 50_000;
  localparam int unsigned P_100HZ  = 500_000;
  localparam int unsigned P_10HZ   = 5_000_000;
  localparam int unsigned P_1HZ    = 50_000_000;

  // Lower acceptance bound, clamped at zero when the tolerance exceeds the period.
  function automatic int unsigned lower_bound(input int unsigned exp_period,
                                              input int unsigned tolerance);
    return (tolerance > exp_period) ? 0 : exp_period - tolerance;
  endfunction

endpackage

// File: rtl/mon_sync_edge.sv
// Two-flop synchronizer for the monitored clock plus a rising-edge detector.
// level_o is the synchronized level; rise_o is high for one clk cycle per edge.
module mon_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, sync3_q;

  // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~sync3_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures rising-edge to rising-edge period of mon_clk in clk cycles, flags
// short/long/missing periods and declares lock. CLK_PERIOD_MONITOR_DUTY_EN adds high-time checking.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned EXP_PERIOD = 10,
  parameter int unsigned TOLERANCE  = 0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             too_fast,
  output logic             too_slow,
  output logic             stalled,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_bad
`endif
);

  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(lower_bound(EXP_PERIOD, TOLERANCE));
  localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(EXP_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(2 * EXP_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_COUNT);

  logic level, rise;

  mon_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(mon_clk),
    .level_o(level),
    .rise_o (rise)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, cnt_inc;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic valid_q, valid_d, fast_q, fast_d, slow_q, slow_d;
  logic stalled_q, stalled_d, locked_q, locked_d;
  logic fast_now, slow_now, period_upd;

  assign fast_now   = cnt_q < LO_LIM;
  assign slow_now   = cnt_q > HI_LIM;
  assign period_upd = (state_q == MEASURE) && rise;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  assign err_inc    = (&err_q) ? err_q : err_q + ERR_ONE;
  assign run_inc    = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    fast_d    = fast_q;
    slow_d    = slow_q;
    stalled_d = stalled_q;
    locked_d  = locked_q;
    run_d     = run_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // An edge on the timeout cycle wins over the stall.
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          fast_d   = fast_now;
          slow_d   = slow_now;
          cnt_d    = CNT_ONE;
          if (fast_now || slow_now) begin
            run_d    = '0;
            locked_d = 1'b0;
            err_d    = err_inc;
          end else begin
            run_d    = run_inc;
            locked_d = (run_inc == RUN_MAX);
          end
        end else if (cnt_q >= STALL_LIM) begin
          state_d   = STALL;
          stalled_d = 1'b1;
          locked_d  = 1'b0;
          run_d     = '0;
          err_d     = err_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STALL: begin
        if (rise) begin
          cnt_d     = CNT_ONE;
          stalled_d = 1'b0;
          state_d   = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      fast_q    <= 1'b0;
      slow_q    <= 1'b0;
      stalled_q <= 1'b0;
      locked_q  <= 1'b0;
      run_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      fast_q    <= fast_d;
      slow_q    <= slow_d;
      stalled_q <= stalled_d;
      locked_q  <= locked_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign too_fast     = fast_q;
  assign too_slow     = slow_q;
  assign stalled      = stalled_q;
  assign locked       = locked_q;
  assign err_cnt      = err_q;

`ifdef CLK_PERIOD_MONITOR_DUTY_EN
  localparam logic [CNT_W-1:0] DUTY_LIM = CNT_W'(TOLERANCE + 1);

  logic [CNT_W-1:0] hi_q, hi_d, high_time_q, high_time_d, half_per, hi_diff;
  logic             duty_bad_q, duty_bad_d;

  // hi_q counts synchronized-high cycles in the same window cnt_q counts.
  always_comb begin
    hi_d        = hi_q;
    high_time_d = high_time_q;
    duty_bad_d  = duty_bad_q;
    half_per    = cnt_q >> 1;
    hi_diff     = (hi_q > half_per) ? hi_q - half_per : half_per - hi_q;
    if (rise) begin
      hi_d = CNT_ONE;
    end else if (level && !(&hi_q)) begin
      hi_d = hi_q + CNT_ONE;
    end
    if (period_upd) begin
      high_time_d = hi_q;
      duty_bad_d  = hi_diff > DUTY_LIM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q        <= '0;
      high_time_q <= '0;
      duty_bad_q  <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      high_time_q <= high_time_d;
      duty_bad_q  <= duty_bad_d;
    end
  end

  assign high_time = high_time_q;
  assign duty_bad  = duty_bad_q;
`else
  logic unused_level;
  assign unused_level = level;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: two instances (TOL=0 and TOL=2) driven
// with directed mon_clk waveforms; expected reports are queued and checked on each period_valid.
module tb_clk_period_monitor;

  typedef struct packed {
    logic [31:0] period;
    logic        fast;
    logic        slow;
    logic        locked;
    logic [15:0] err;
    logic [31:0] hi;
    logic        dbad;
  } rep_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_a = 1'b0;
  logic mon_b = 1'b0;

  logic [31:0] period_a, period_b;
  logic        valid_a, valid_b, fast_a, fast_b, slow_a, slow_b;
  logic        stalled_a, stalled_b, locked_a, locked_b;
  logic [15:0] err_a, err_b;
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
  logic [31:0] hi_a, hi_b;
  logic        dbad_a, dbad_b;
`endif

  rep_t q_a[$];
  rep_t q_b[$];
  int   checks = 0;
  int   failures = 0;

  always #10 clk = ~clk;

  clk_period_monitor #(
    .CNT_W(32), .EXP_PERIOD(10), .TOLERANCE(0), .LOCK_COUNT(4), .ERR_W(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mon_clk(mon_a),
    .period(period_a), .period_valid(valid_a), .too_fast(fast_a), .too_slow(slow_a),
    .stalled(stalled_a), .locked(locked_a), .err_cnt(err_a)
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
    , .high_time(hi_a), .duty_bad(dbad_a)
`endif
  );

  clk_period_monitor #(
    .CNT_W(32), .EXP_PERIOD(10), .TOLERANCE(2), .LOCK_COUNT(4), .ERR_W(16)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mon_clk(mon_b),
    .period(period_b), .period_valid(valid_b), .too_fast(fast_b), .too_slow(slow_b),
    .stalled(stalled_b), .locked(locked_b), .err_cnt(err_b)
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
    , .high_time(hi_b), .duty_bad(dbad_b)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_rep(input string tag, input rep_t e, input logic [31:0] p,
                         input logic f, input logic s, input logic l, input logic [15:0] er,
                         input logic [31:0] hi, input logic db);
    check({tag, "_period"}, p, e.period);
    check({tag, "_too_fast"}, f, e.fast);
    check({tag, "_too_slow"}, s, e.slow);
    check({tag, "_locked"}, l, e.locked);
    check({tag, "_err_cnt"}, er, e.err);
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
    check({tag, "_high_time"}, hi, e.hi);
    check({tag, "_duty_bad"}, db, e.dbad);
`else
    if (hi !== 32'd0 || db !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s_duty_tieoff: got %0d/%0d, expected 0/0", tag, hi, db);
    end
`endif
  endtask

  // Monitors: every period_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    rep_t e;
    if (valid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_valid: got period %0d, expected no pulse", period_a);
      end else begin
        e = q_a.pop_front();
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
        cmp_rep("a", e, period_a, fast_a, slow_a, locked_a, err_a, hi_a, dbad_a);
`else
        cmp_rep("a", e, period_a, fast_a, slow_a, locked_a, err_a, 32'd0, 1'b0);
`endif
      end
    end
  end

  always @(negedge clk) begin
    rep_t e;
    if (valid_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_valid: got period %0d, expected no pulse", period_b);
      end else begin
        e = q_b.pop_front();
`ifdef CLK_PERIOD_MONITOR_DUTY_EN
        cmp_rep("b", e, period_b, fast_b, slow_b, locked_b, err_b, hi_b, dbad_b);
`else
        cmp_rep("b", e, period_b, fast_b, slow_b, locked_b, err_b, 32'd0, 1'b0);
`endif
      end
    end
  end

  // Queue the report the DUT must give for the period ending at the next edge.
  task automatic exp_rep(input bit b, input int per, input bit f, input bit s, input bit l,
                         input int err, input int hi, input bit dbad);
    rep_t e;
    e = '{period: 32'(per), fast: f, slow: s, locked: l, err: 16'(err), hi: 32'(hi), dbad: dbad};
    if (b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  // One mon_clk cycle starting with a rising edge: high for 'high' clk cycles, low for the rest.
  task automatic drive(input bit b, input int len, input int high);
    for (int i = 0; i < len; i++) begin
      if (b) mon_b = (i < high);
      else mon_a = (i < high);
      @(negedge clk);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_period"}, period_a, 0);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_too_fast"}, fast_a, 0);
    check({tag, "_too_slow"}, slow_a, 0);
    check({tag, "_stalled"}, stalled_a, 0);
    check({tag, "_locked"}, locked_a, 0);
    check({tag, "_err_cnt"}, err_a, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset_b_period", period_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal 10-cycle clock: lock on the 5th edge, then short, long and recovery.
    drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 0, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 0, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 0, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 1, 0, 5, 0); drive(0, 8, 4);
    exp_rep(0, 8, 1, 0, 0, 1, 4, 0);  drive(0, 8, 4);
    exp_rep(0, 8, 1, 0, 0, 2, 4, 0);  drive(0, 11, 5);
    exp_rep(0, 11, 0, 1, 0, 3, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 3, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 3, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 3, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 1, 3, 5, 0);

    // Last edge, then mon_clk stops: stall when cnt hits 20 (23 cycles after the edge).
    mon_a = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) mon_a = 1'b0;
      if (stalled_a) break;
    end
    check("a_stall_latency", k, 23);
    check("a_stall_stalled", stalled_a, 1);
    check("a_stall_locked", locked_a, 0);
    check("a_stall_err", err_a, 4);
    repeat (5) @(negedge clk);
    check("a_stall_held", stalled_a, 1);
    check("a_stall_err_once", err_a, 4);

    // Restart: first edge clears stalled without a report, run count starts over.
    drive(0, 10, 5);
    check("a_restart_stalled", stalled_a, 0);
    exp_rep(0, 10, 0, 0, 0, 4, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 4, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 4, 5, 0); drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 1, 4, 5, 0);
    for (int i = 0; i < 7; i++) begin
      mon_a = (i < 5);
      @(negedge clk);
    end
    check("a_pre_reset_locked", locked_a, 1);

    // One-cycle reset mid-period clears everything; first new edge is silent.
    rst_n = 1'b0;
    @(negedge clk);
    check_a_zero("midreset");
    rst_n = 1'b1;
    drive(0, 10, 5);
    exp_rep(0, 10, 0, 0, 0, 0, 5, 0); drive(0, 10, 3);
    exp_rep(0, 10, 0, 0, 0, 0, 3, 1); drive(0, 10, 5);

    // Tolerance boundaries on the TOL=2 instance: 8/12 good, 7/13 bad.
    drive(1, 10, 5);
    exp_rep(1, 10, 0, 0, 0, 0, 5, 0); drive(1, 8, 4);
    exp_rep(1, 8, 0, 0, 0, 0, 4, 0);  drive(1, 12, 6);
    exp_rep(1, 12, 0, 0, 0, 0, 6, 0); drive(1, 9, 4);
    exp_rep(1, 9, 0, 0, 1, 0, 4, 0);  drive(1, 7, 3);
    exp_rep(1, 7, 1, 0, 0, 1, 3, 0);  drive(1, 13, 6);
    exp_rep(1, 13, 0, 1, 0, 2, 6, 0); drive(1, 10, 5);
    exp_rep(1, 10, 0, 0, 0, 2, 5, 0); drive(1, 10, 5);

    repeat (5) @(negedge clk);
    check("a_reports_missing", q_a.size(), 0);
    check("b_reports_missing", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
